// File: rtl/apu_mix_pkg.sv
// Shared constants for the APU mixer gain multipliers.
// Operand/product widths and the fixed per-channel gains live here.
package apu_mix_pkg;

  localparam int MIX_OP_W   = 8;
  localparam int MIX_PROD_W = 16;

  localparam logic [MIX_OP_W-1:0] PULSE_GAIN = 8'd144;
  localparam logic [MIX_OP_W-1:0] TRI_GAIN   = 8'd162;
  localparam logic [MIX_OP_W-1:0] NOISE_GAIN = 8'd94;

endpackage

// File: rtl/apu_mult_pp_row.sv
// One row of the array multiplier: adds dataa, gated by one multiplier bit
// and shifted to that bit's weight, onto the running partial sum.
module apu_mult_pp_row #(
  parameter int A_WIDTH = 8,
  parameter int P_WIDTH = 16,
  parameter int SHIFT   = 0
) (
  input  logic [P_WIDTH-1:0] sum_in,
  input  logic [A_WIDTH-1:0] dataa,
  input  logic               b_bit,
  output logic [P_WIDTH-1:0] sum_out
);

  logic [A_WIDTH-1:0] pp_gated;
  logic [P_WIDTH-1:0] pp_shifted;

  always_comb begin
    pp_gated   = dataa & {A_WIDTH{b_bit}};
    pp_shifted = P_WIDTH'(pp_gated) << SHIFT;
    sum_out    = sum_in + pp_shifted;
  end

endmodule

// File: rtl/apu_mult8x8.sv
// Unsigned A_WIDTH x B_WIDTH multiplier built from a ripple array of
// partial-product rows, with an optional one-cycle output register.
module apu_mult8x8
  import apu_mix_pkg::*;
#(
  parameter int A_WIDTH = MIX_OP_W,
  parameter int B_WIDTH = MIX_OP_W,
  parameter bit OUT_REG = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [A_WIDTH-1:0]         dataa,
  input  logic [B_WIDTH-1:0]         datab,
  output logic [A_WIDTH+B_WIDTH-1:0] result
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  // sum_chain[i] is the sum of the first i partial products.
  logic [P_WIDTH-1:0] sum_chain [B_WIDTH+1];

  assign sum_chain[0] = '0;

  for (genvar i = 0; i < B_WIDTH; i++) begin : g_row
    apu_mult_pp_row #(
      .A_WIDTH (A_WIDTH),
      .P_WIDTH (P_WIDTH),
      .SHIFT   (i)
    ) u_row (
      .sum_in  (sum_chain[i]),
      .dataa   (dataa),
      .b_bit   (datab[i]),
      .sum_out (sum_chain[i+1])
    );
  end

  if (OUT_REG) begin : g_out_reg
    logic [P_WIDTH-1:0] result_d;
    logic [P_WIDTH-1:0] result_q;

    always_comb begin
      result_d = sum_chain[B_WIDTH];
    end

    // NOTE: state updates use <= so every flop samples pre-edge values;
    // a blocking = here would let later readers see the new value early.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) result_q <= '0;
      else        result_q <= result_d;
    end

    assign result = result_q;
  end else begin : g_out_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign result         = sum_chain[B_WIDTH];
  end

endmodule

// File: tb/tb_apu_mult8x8.sv
// Self-checking bench for apu_mult8x8: one combinational and one registered
// instance, checked against plain a*b arithmetic.
module tb_apu_mult8x8;
  import apu_mix_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a0, b0, a1, b1;
  logic [15:0] res0, res1;

  int errors = 0;
  int checks = 0;

  apu_mult8x8 #(.A_WIDTH(8), .B_WIDTH(8), .OUT_REG(1'b0)) u_comb (
    .clk    (clk),
    .rst_n  (rst_n),
    .dataa  (a0),
    .datab  (b0),
    .result (res0)
  );

  apu_mult8x8 #(.A_WIDTH(8), .B_WIDTH(8), .OUT_REG(1'b1)) u_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .dataa  (a1),
    .datab  (b1),
    .result (res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input int a, input int b);
    return 16'(a * b);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 8'd55; b1 = 8'd66;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", res1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mixer_gains();
    logic [15:0] exp_v;
    int pairs [3][2] = '{'{31, PULSE_GAIN}, '{15, TRI_GAIN}, '{15, NOISE_GAIN}};
    int want  [3]    = '{4464, 2430, 1410};
    for (int i = 0; i < 3; i++) begin
      a0 = 8'(pairs[i][0]); b0 = 8'(pairs[i][1]);
      #1;
      exp_v = 16'(want[i]);
      checks++;
      if (res0 !== exp_v) begin
        errors++;
        $display("FAIL gain_%0d: got %0d want %0d", i, res0, exp_v);
      end
    end
    a0 = 8'd31; b0 = PULSE_GAIN;
    #1;
    checks++;
    if (res0[12:6] !== 7'd69) begin
      errors++;
      $display("FAIL pulse_slice: got %0d want 69", res0[12:6]);
    end
  endtask

  task automatic test_boundaries();
    int pairs [5][2] = '{'{255, 255}, '{0, 171}, '{171, 0}, '{1, 171}, '{171, 1}};
    int want  [5]    = '{65025, 0, 0, 171, 171};
    for (int i = 0; i < 5; i++) begin
      a0 = 8'(pairs[i][0]); b0 = 8'(pairs[i][1]);
      #1;
      checks++;
      if (res0 !== 16'(want[i])) begin
        errors++;
        $display("FAIL boundary_%0d: got %0d want %0d", i, res0, want[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    int shown = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        a0 = 8'(a); b0 = 8'(b);
        #1;
        checks++;
        if (res0 !== ref_mul(a, b)) begin
          errors++;
          if (shown < 5)
            $display("FAIL sweep %0d*%0d: got %0d want %0d", a, b, res0, ref_mul(a, b));
          shown++;
        end
      end
    end
  endtask

  task automatic test_registered_latency();
    @(negedge clk);
    a1 = 8'd3; b1 = 8'd7;
    @(posedge clk);
    #1;
    a1 = 8'd0; b1 = 8'd0;
    checks++;
    if (res1 !== 16'd21) begin
      errors++;
      $display("FAIL latency_3x7: got %0d want 21", res1);
    end
  endtask

  task automatic test_back_to_back();
    int ops [3][2] = '{'{3, 7}, '{200, 100}, '{255, 2}};
    int want [3]   = '{21, 20000, 510};
    int ra, rb;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a1 = 8'(ops[i][0]); b1 = 8'(ops[i][1]);
      @(posedge clk);
      #1;
      checks++;
      if (res1 !== 16'(want[i])) begin
        errors++;
        $display("FAIL b2b_%0d: got %0d want %0d", i, res1, want[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(255)); rb = int'($urandom_range(255));
      @(negedge clk);
      a1 = 8'(ra); b1 = 8'(rb);
      @(posedge clk);
      #1;
      checks++;
      if (res1 !== ref_mul(ra, rb)) begin
        errors++;
        $display("FAIL b2b_rand %0d*%0d: got %0d want %0d", ra, rb, res1, ref_mul(ra, rb));
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a1 = 8'd200; b1 = 8'd100;
    @(posedge clk);
    #1;
    checks++;
    if (res1 !== 16'd20000) begin
      errors++;
      $display("FAIL hold_20000: got %0d want 20000", res1);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res1 !== 16'd0) begin
      errors++;
      $display("FAIL async_clear: got %0d want 0", res1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res1 !== 16'd0) begin
        errors++;
        $display("FAIL reset_hold_%0d: got %0d want 0", i, res1);
      end
    end
    @(negedge clk);
    a1 = 8'd9; b1 = 8'd9;
    rst_n = 1'b1;
    #1;
    checks++;
    if (res1 !== 16'd0) begin
      errors++;
      $display("FAIL no_stale_after_release: got %0d want 0", res1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (res1 !== 16'd81) begin
      errors++;
      $display("FAIL release_9x9: got %0d want 81", res1);
    end
  endtask

  task automatic test_comb_ignores_clk();
    a0 = 8'd12; b0 = 8'd12;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = i[0];
      #1;
      checks++;
      if (res0 !== 16'd144) begin
        errors++;
        $display("FAIL comb_static_neg_%0d: got %0d want 144", i, res0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (res0 !== 16'd144) begin
        errors++;
        $display("FAIL comb_static_pos_%0d: got %0d want 144", i, res0);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_mixer_gains();
    test_boundaries();
    test_exhaustive();
    test_registered_latency();
    test_back_to_back();
    test_async_reset();
    test_comb_ignores_clk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
